// File: rtl/fifo_ref_checker.sv
// fifo_ref_checker: passive observer for one FIFO instance.
// A shadow model tracks occupancy, flags and data from the FIFO's request
// lines. Each cycle the FIFO's flags and registered outputs are compared
// against the model. The results are accumulated into saturating pass/fail
// counters, along with first-failure and last-failure check masks.
module fifo_ref_checker #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_GAP     = 1,
  parameter int AE_GAP     = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          chk_en,
  input  logic                          wr_en,
  input  logic                          rd_en,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic [DATA_WIDTH-1:0]         data_out,
  input  logic                          wr_ack,
  input  logic                          overflow,
  input  logic                          underflow,
  input  logic                          full,
  input  logic                          empty,
  input  logic                          almostfull,
  input  logic                          almostempty,
  output logic [CNT_WIDTH-1:0]          ok_count,
  output logic [CNT_WIDTH-1:0]          err_count,
  output logic                          err_sticky,
  output logic [7:0]                    first_err_mask,
  output logic [7:0]                    last_err_mask,
  output logic [$clog2(FIFO_DEPTH):0]   shadow_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(FIFO_DEPTH - AF_GAP);
  localparam logic [CW-1:0] AE_C    = CW'(AE_GAP);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  logic                  exp_wr_ack;
  logic                  exp_overflow;
  logic                  exp_underflow;
  logic                  exp_rd_valid;
  logic [DATA_WIDTH-1:0] exp_data;

  logic                  model_full;
  logic                  model_empty;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [7:0]            mask;

  // Model flags, accepted handshakes and the per-cycle check mask.
  // All of these use the occupancy held before the current edge.
  always_comb begin
    model_full  = (shadow_count == DEPTH_C);
    model_empty = (shadow_count == '0);
    wr_acc      = wr_en && !model_full;
    rd_acc      = rd_en && !model_empty;
    mask        = '0;
    mask[0]     = (full        != model_full);
    mask[1]     = (empty       != model_empty);
    mask[2]     = (almostfull  != (shadow_count == AF_C));
    mask[3]     = (almostempty != (shadow_count == AE_C));
    mask[4]     = (wr_ack      != exp_wr_ack);
    mask[5]     = (overflow    != exp_overflow);
    mask[6]     = (underflow   != exp_underflow);
    mask[7]     = exp_rd_valid && (data_out != exp_data);
  end

  // Shadow storage. It has no reset because its contents are never
  // read before being written.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy and the registered outputs expected from the FIFO
  // after this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      shadow_count  <= '0;
      exp_wr_ack    <= 1'b0;
      exp_overflow  <= 1'b0;
      exp_underflow <= 1'b0;
      exp_rd_valid  <= 1'b0;
      exp_data      <= '0;
    end else begin
      exp_wr_ack    <= wr_acc;
      exp_overflow  <= wr_en && model_full;
      exp_underflow <= rd_en && model_empty;
      exp_rd_valid  <= rd_acc;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        exp_data <= mem[rd_ptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   shadow_count <= shadow_count + CW'(1);
        2'b01:   shadow_count <= shadow_count - CW'(1);
        default: shadow_count <= shadow_count;
      endcase
    end
  end

  // Score each enabled cycle, and capture failure masks.
  // Both counters stop at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ok_count       <= '0;
      err_count      <= '0;
      err_sticky     <= 1'b0;
      first_err_mask <= '0;
      last_err_mask  <= '0;
    end else if (chk_en) begin
      if (mask == '0) begin
        if (ok_count != '1) begin
          ok_count <= ok_count + CNT_WIDTH'(1);
        end
      end else begin
        if (err_count != '1) begin
          err_count <= err_count + CNT_WIDTH'(1);
        end
        last_err_mask <= mask;
        if (!err_sticky) begin
          first_err_mask <= mask;
          err_sticky     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/fifo_ref_checker.md
# fifo_ref_checker

Synthesisable, parametrised FIFO checker. It shadows the handshake of one FIFO instance with an internal reference model of occupancy, flags and data. Every clock it compares the FIFO's flag and data outputs against the model and keeps saturating correct/error counts plus first-failure capture. It sits beside the FIFO as a bus-level observer, replacing the class-based monitor for emulation and on-silicon debug. It never drives the FIFO.

## Interface
- `DATA_WIDTH`, default 16: FIFO data width.
- `FIFO_DEPTH`, default 8: entries in the observed FIFO; must be ≥4 and a power of two.
- `AF_GAP`, default 1: `almostfull` is expected when count == `FIFO_DEPTH`-`AF_GAP`.
- `AE_GAP`, default 1: `almostempty` is expected when count == `AE_GAP`.
- `CNT_WIDTH`, default 16: width of `ok_count` and `err_count`.

Ports:
- `clk`  in  1  sole clock; all logic on posedge.
- `rst_n`  in  1  synchronous, active-low reset; shared with the observed FIFO.
- `chk_en`  in  1  comparison enable; the model tracks regardless.
- `wr_en`, `rd_en`  in  1 each  FIFO requests.
- `data_in`  in  `DATA_WIDTH`  FIFO write data.
- `data_out`  in  `DATA_WIDTH`  FIFO read data (registered in FIFO).
- `wr_ack`, `overflow`, `underflow`  in  1 each  FIFO registered status.
- `full`, `empty`, `almostfull`, `almostempty`  in  1 each  FIFO combinational flags.
- `ok_count`, `err_count`  out  `CNT_WIDTH`  saturating counts of passing and failing cycles.
- `err_sticky`  out  1  set on the first failure; cleared only by reset.
- `first_err_mask`  out  8  failing-check bits of the first failing cycle.
- `last_err_mask`  out  8  failing-check bits of the most recent failing cycle.
- `shadow_count`  out  `$clog2(FIFO_DEPTH)+1`  model occupancy.

## Operation
- Model contract for the observed FIFO:
  - A write is accepted iff `wr_en` && !full(model). A read is accepted iff `rd_en` && !empty(model).
  - Both requests accepted in the same cycle: count is unchanged.
  - When full, only the read proceeds. When empty, only the write proceeds.
- Shadow memory: `FIFO_DEPTH` x `DATA_WIDTH`, with wrapping write and read pointers.
  - Count is 0..`FIFO_DEPTH`; it never wraps.
- Expected registered outputs, computed at edge t and compared at edge t+1:
  - exp_wr_ack = write accepted.
  - exp_overflow = `wr_en` && model full.
  - exp_underflow = `rd_en` && model empty.
  - exp_data = mem[rd_ptr] when the read is accepted, with exp_rd_valid set; otherwise exp_rd_valid is 0 and exp_data holds.
- Check bits, each set when the comparison fails:
  - [0] full vs (count==DEPTH)
  - [1] empty vs (count==0)
  - [2] almostfull vs (count==DEPTH-AF_GAP)
  - [3] almostempty vs (count==AE_GAP)
  - [4] wr_ack
  - [5] overflow
  - [6] underflow
  - [7] data_out, evaluated only when exp_rd_valid=1
- Per cycle with `rst_n`=1 and `chk_en`=1:
  - mask == 0: `ok_count`+1.
  - mask != 0: `err_count`+1 and `last_err_mask`=mask. If `err_sticky` was 0, also `first_err_mask`=mask and `err_sticky`=1.
- Both counters saturate at all-ones.
- With `chk_en`=0: no counts, masks or sticky change; the model still updates.

## Timing
- Reset (`rst_n`=0 at posedge): clears to 0 the pointers, count, exp_* registers, exp_rd_valid, both counters, both masks and `err_sticky`.
  - Reset mid-operation behaves the same way; shadow memory contents are don't-care.
- Comparisons at edge t use flag inputs sampled just before the edge against the count held before the edge.
  - The model then updates at the same edge.
- The first edge after reset release is checked. The FIFO's registered outputs are 0 out of reset, which matches the reset exp_* values.
- Output latency: counts, masks and sticky reflect edge t's comparison right after edge t, i.e. 1-cycle registered.
- `shadow_count` is registered. It equals the FIFO's internal count after each edge.
- No combinational path from inputs to outputs.

## Test plan
Use `FIFO_DEPTH`=8, AF/AE gaps 1 and a correct FIFO model unless stated.
- Reset, then 8 writes of 0x0001..0x0008 and 8 reads → data_out 0x0001..0x0008 in order. `err_count`=0, `ok_count`=17, `shadow_count` ends at 0.
- Fill to 8, then 3 further writes → overflow expected high for 3 cycles. `shadow_count` stays 8, `err_count`=0.
- Read while empty for 2 cycles → exp_underflow=1 twice, with no error. Then force FIFO `underflow`=0 on the next such read → `err_count`=1, `first_err_mask`=0x40, `err_sticky`=1.
- Count=8 with `wr_en`=`rd_en`=1 → read only, count 7. Count=0 with both high → write only, count 1. Zero errors.
- Corrupt one read word (0x00A5 returned as 0x00A4), then corrupt `full` later → `first_err_mask`=0x80, `last_err_mask`=0x01, `err_count`=2.
- Pulse `rst_n` low for 1 cycle with count=5 and `err_count`=3 → all outputs 0 next cycle. A following write/read of 0x1234 passes.
